// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the FIFO flow-control state machine.
// Holds the state width and the state enumeration so the design and any
// debug tooling agree on the binary encoding of each state.
package flow_ctrl_pkg;

   localparam int STATE_W = 3;

   // Binary state encoding; values 5..7 are unused and treated as illegal
   typedef enum logic [STATE_W-1:0] {
      RESET  = 3'd0,
      IDLE   = 3'd1,
      ACTIVE = 3'd2,
      PAUSE  = 3'd3,
      ERROR  = 3'd4
   } flowState_t;

endpackage

// File: rtl/flow_ctrl_fsm.sv
// Flow-control state machine for the FIFO datapath.
// Watches the FIFO fill flags plus a start request and tells the upstream
// source whether it may keep writing (continuar), must hold (pausa), has
// overflowed (error_full), or is waiting to be started (idle).
// Moore machine: the status outputs depend only on the state register, so
// each one changes exactly one clock edge after the flag that caused it.
// Optional build macro FLOW_CTRL_STATE_OUT_EN adds a debug port state_o that
// mirrors the state register.
module flow_ctrl_fsm
   import flow_ctrl_pkg::*;
#(
   parameter bit IDLE_ON_EMPTY = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic iniciar,
   input  logic almost_full,
   input  logic full,
   input  logic almost_empty,
   input  logic empty,
   output logic continuar,
   output logic pausa,
   output logic error_full,
   output logic idle
`ifdef FLOW_CTRL_STATE_OUT_EN
   ,
   output logic [STATE_W-1:0] state_o
`endif
);

   flowState_t stateReg;
   flowState_t stateNext;

   // State register. Reset is asynchronous so that all status outputs drop
   // the moment reset rises, even from the sticky ERROR state, without
   // waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg <= RESET;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state logic. Within each state the checks are ordered so the first
   // match wins: full always beats almost_full and empty, which is what keeps
   // an overflow from being masked by a simultaneous pause or drain. In IDLE
   // only iniciar matters; the fill flags are first looked at from ACTIVE on
   // the following edge. ERROR is sticky until reset. Any unused encoding
   // falls back to RESET so the machine always recovers.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         RESET: begin
            stateNext = IDLE;
         end
         IDLE: begin
            if (iniciar) begin
               stateNext = ACTIVE;
            end
         end
         ACTIVE: begin
            if (full) begin
               stateNext = ERROR;
            end else if (almost_full) begin
               stateNext = PAUSE;
            end else if (empty && IDLE_ON_EMPTY) begin
               stateNext = IDLE;
            end
         end
         PAUSE: begin
            if (full) begin
               stateNext = ERROR;
            end else if (almost_empty || empty) begin
               stateNext = ACTIVE;
            end
         end
         ERROR: begin
            stateNext = ERROR;
         end
         default: begin
            stateNext = RESET;
         end
      endcase
   end

   // Output decode straight from the state register. Exactly one status line
   // is high in every legal non-RESET state; RESET and any unused encoding
   // drive all four low.
   always_comb begin
      continuar  = 1'b0;
      pausa      = 1'b0;
      error_full = 1'b0;
      idle       = 1'b0;
      case (stateReg)
         IDLE:    idle       = 1'b1;
         ACTIVE:  continuar  = 1'b1;
         PAUSE:   pausa      = 1'b1;
         ERROR:   error_full = 1'b1;
         default: begin
            continuar  = 1'b0;
            pausa      = 1'b0;
            error_full = 1'b0;
            idle       = 1'b0;
         end
      endcase
   end

`ifdef FLOW_CTRL_STATE_OUT_EN
   // Debug view of the raw state encoding
   always_comb begin
      state_o = stateReg;
   end
`endif

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Self-checking bench for flow_ctrl_fsm.
// The reference model tracks only which status line should be high and
// applies the flow-control rules to that; a compare process checks the DUT
// against it on every falling edge, and directed checks pin both the DUT and
// the model to hand-computed values.
module tb_flow_ctrl_fsm;

   logic clk;
   logic reset;
   logic iniciar;
   logic almost_full;
   logic full;
   logic almost_empty;
   logic empty;
   logic continuar;
   logic pausa;
   logic error_full;
   logic idle;
`ifdef FLOW_CTRL_STATE_OUT_EN
   logic [2:0] state_o;
`endif

   int checkCount = 0;
   int errorCount = 0;

   // Expected status lines packed as {continuar, pausa, error_full, idle};
   // all zero means the machine is in (or just left) reset.
   logic [3:0] mOut = 4'b0000;

   localparam logic [3:0] OUT_NONE  = 4'b0000;
   localparam logic [3:0] OUT_CONT  = 4'b1000;
   localparam logic [3:0] OUT_PAUSA = 4'b0100;
   localparam logic [3:0] OUT_ERR   = 4'b0010;
   localparam logic [3:0] OUT_IDLE  = 4'b0001;

   flow_ctrl_fsm #(.IDLE_ON_EMPTY(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .iniciar      (iniciar),
      .almost_full  (almost_full),
      .full         (full),
      .almost_empty (almost_empty),
      .empty        (empty),
      .continuar    (continuar),
      .pausa        (pausa),
      .error_full   (error_full),
      .idle         (idle)
`ifdef FLOW_CTRL_STATE_OUT_EN
      ,
      .state_o      (state_o)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: reset clears every line at once; otherwise each rising
   // edge moves the single expected line according to the flow rules.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mOut = OUT_NONE;
      end else if (mOut == OUT_NONE) begin
         mOut = OUT_IDLE;
      end else if (mOut == OUT_IDLE) begin
         if (iniciar) mOut = OUT_CONT;
      end else if (mOut == OUT_CONT) begin
         if (full) mOut = OUT_ERR;
         else if (almost_full) mOut = OUT_PAUSA;
         else if (empty) mOut = OUT_IDLE;
      end else if (mOut == OUT_PAUSA) begin
         if (full) mOut = OUT_ERR;
         else if (almost_empty || empty) mOut = OUT_CONT;
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model on falling edges
   always @(negedge clk) begin
      checkCount++;
      if ({continuar, pausa, error_full, idle} !== mOut) begin
         errorCount++;
         $display("[TB] FAIL cycle-compare t=%0t got %b expected %b",
                  $time, {continuar, pausa, error_full, idle}, mOut);
      end
`ifdef FLOW_CTRL_STATE_OUT_EN
      begin
         logic [2:0] expState;
         case (mOut)
            OUT_IDLE:  expState = 3'd1;
            OUT_CONT:  expState = 3'd2;
            OUT_PAUSA: expState = 3'd3;
            OUT_ERR:   expState = 3'd4;
            default:   expState = 3'd0;
         endcase
         checkCount++;
         if (state_o !== expState) begin
            errorCount++;
            $display("[TB] FAIL state-compare t=%0t got %0d expected %0d",
                     $time, state_o, expState);
         end
      end
`endif
   end

   // Drive one cycle of inputs just after the falling edge
   task automatic applyStimulus(input logic ini, input logic af, input logic f,
                                input logic ae, input logic e);
      @(negedge clk);
      #1;
      iniciar      = ini;
      almost_full  = af;
      full         = f;
      almost_empty = ae;
      empty        = e;
   endtask

   // Check both the DUT and the model against a hand-computed value
   task automatic checkOutput(input string name, input logic [3:0] expected);
      checkCount++;
      if ({continuar, pausa, error_full, idle} !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s dut got %b expected %b", name,
                  {continuar, pausa, error_full, idle}, expected);
      end
      checkCount++;
      if (mOut !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s model got %b expected %b", name, mOut, expected);
      end
   endtask

   task automatic stepAndCheck(input string name, input logic [3:0] expected);
      @(posedge clk);
      #2;
      checkOutput(name, expected);
   endtask

   task automatic setReset(input logic value);
      @(negedge clk);
      #1;
      reset = value;
   endtask

   initial begin
      reset        = 1'b1;
      iniciar      = 1'b0;
      almost_full  = 1'b0;
      full         = 1'b0;
      almost_empty = 1'b0;
      empty        = 1'b0;

      #12;
      checkOutput("reset-held", OUT_NONE);
      setReset(1'b0);
      stepAndCheck("reset-release-edge1", OUT_IDLE);
      stepAndCheck("reset-release-edge2", OUT_IDLE);

      // Start and run
      applyStimulus(1, 0, 0, 0, 0);
      stepAndCheck("start", OUT_CONT);
      applyStimulus(0, 0, 0, 0, 0);
      stepAndCheck("run-stay", OUT_CONT);

      // Pause and resume
      applyStimulus(0, 1, 0, 0, 0);
      stepAndCheck("pause", OUT_PAUSA);
      applyStimulus(0, 0, 0, 1, 0);
      stepAndCheck("resume", OUT_CONT);

      // Overflow beats almost_full on the same edge, then stays sticky
      applyStimulus(0, 1, 1, 0, 0);
      stepAndCheck("overflow-priority", OUT_ERR);
      applyStimulus(0, 0, 0, 0, 0);
      stepAndCheck("error-sticky", OUT_ERR);
      applyStimulus(1, 0, 0, 0, 1);
      stepAndCheck("error-ignores-iniciar", OUT_ERR);

      // Asynchronous clear out of ERROR
      setReset(1'b1);
      #1;
      checkOutput("error-async-reset", OUT_NONE);
      applyStimulus(0, 0, 0, 0, 0);
      reset = 1'b0;
      stepAndCheck("error-reset-release", OUT_IDLE);

      // iniciar with flags in IDLE only starts; empty from ACTIVE returns
      applyStimulus(1, 1, 1, 0, 1);
      stepAndCheck("start-ignores-flags", OUT_CONT);
      applyStimulus(0, 0, 0, 0, 1);
      stepAndCheck("empty-to-idle", OUT_IDLE);

      // Reset between edges while paused
      applyStimulus(1, 0, 0, 0, 0);
      stepAndCheck("restart", OUT_CONT);
      applyStimulus(0, 1, 0, 0, 0);
      stepAndCheck("pause-again", OUT_PAUSA);
      applyStimulus(0, 0, 0, 0, 0);
      stepAndCheck("pause-hold", OUT_PAUSA);
      setReset(1'b1);
      #1;
      checkOutput("pause-async-reset", OUT_NONE);
      setReset(1'b0);
      stepAndCheck("pause-reset-release", OUT_IDLE);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 11) == 0),
                       1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 5) == 0));
         reset = ($urandom_range(0, 39) == 0);
      end
      applyStimulus(0, 0, 0, 0, 0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
